// File: rtl/vga_pkg.sv
// Shared VGA overlay constants: label colours, label band bounds and glyph offsets
// used by the chessboard label overlay.
package vga_pkg;

  localparam int VGA_BUS_W = 38;

  localparam logic [11:0] LETTER_RGB    = 12'hFFF;
  localparam logic [11:0] LETTER_HL_RGB = 12'hF80;

  // File labels (A..H) sit in two horizontal strips above and below the board
  localparam logic [10:0] FILE_H_MIN  = 11'd256;
  localparam logic [10:0] FILE_H_MAX  = 11'd767;
  localparam logic [10:0] FILE_V0_MIN = 11'd104;
  localparam logic [10:0] FILE_V0_MAX = 11'd119;
  localparam logic [10:0] FILE_V1_MIN = 11'd648;
  localparam logic [10:0] FILE_V1_MAX = 11'd663;

  // Rank labels (8..1) sit in two vertical strips left and right of the board
  localparam logic [10:0] RANK_V_MIN  = 11'd128;
  localparam logic [10:0] RANK_V_MAX  = 11'd639;
  localparam logic [10:0] RANK_H0_MIN = 11'd236;
  localparam logic [10:0] RANK_H0_MAX = 11'd243;
  localparam logic [10:0] RANK_H1_MIN = 11'd780;
  localparam logic [10:0] RANK_H1_MAX = 11'd787;

  localparam logic [10:0] FILE_GLYPH_OFS  = 11'd28;
  localparam logic [10:0] RANK_GLYPH_OFS0 = 11'd236;
  localparam logic [10:0] RANK_GLYPH_OFS1 = 11'd780;
  localparam logic [10:0] RANK_ROW_MIN    = 11'd24;
  localparam logic [10:0] RANK_ROW_MAX    = 11'd39;
  localparam logic [10:0] FILE_COL_BASE   = 11'd4;
  localparam logic [10:0] RANK_ROW_BASE   = 11'd2;
  localparam logic [10:0] GLYPH_W         = 11'd8;

  function automatic logic in_range(input logic [10:0] val, input logic [10:0] lo,
                                    input logic [10:0] hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/vga_delay.sv
// Fixed-depth register pipeline for the full VGA bundle; every stage clears on reset
// so a mid-frame reset flushes all in-flight pixels.
module vga_delay
  import vga_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  logic [VGA_BUS_W-1:0] bus_in_s;
  logic [VGA_BUS_W-1:0] pipe_r [DEPTH];

  assign bus_in_s = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in, rgb_in};

  // shift the bundle one stage per clock, clearing every stage on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_r[i] <= '0;
      end
    end else begin
      pipe_r[0] <= bus_in_s;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  assign {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} =
         pipe_r[DEPTH-1];

endmodule

// File: rtl/draw_letters.sv
// Overlays chessboard file/rank labels on a VGA stream with a two-cycle latency,
// highlighting the labels of the selected square; settings are sampled once per frame.
module draw_letters
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  input  logic [7:0]  char_pixels,
  input  logic        letters_en,
  input  logic        sel_valid,
  input  logic [2:0]  sel_col,
  input  logic [2:0]  sel_row,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  logic [10:0] hcount_s1_s, vcount_s1_s;
  logic        hsync_s1_s, vsync_s1_s, hblnk_s1_s, vblnk_s1_s;
  logic [11:0] rgb_s1_s;

  logic        letters_en_r, sel_valid_r;
  logic [2:0]  sel_col_r, sel_row_r;

  logic        file_band_s, rank_band_s, glyph_ok_s, glyph_bit_s, sel_hit_s;
  logic [10:0] file_gx_s, rank_gx_s, glyph_x_s, col_idx_s, row_idx_s, v_row_s;
  logic [11:0] rgb_mix_s;

  vga_delay #(.DEPTH(1)) u_stage1 (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
    .hcount_out(hcount_s1_s), .vcount_out(vcount_s1_s),
    .hsync_out(hsync_s1_s), .vsync_out(vsync_s1_s),
    .hblnk_out(hblnk_s1_s), .vblnk_out(vblnk_s1_s), .rgb_out(rgb_s1_s)
  );

  // capture label settings on the stage-1 vsync rising edge; vsync_out is stage 1 one cycle later
  always_ff @(posedge clk) begin
    if (rst) begin
      letters_en_r <= 1'b1;
      sel_valid_r  <= 1'b0;
      sel_col_r    <= 3'd0;
      sel_row_r    <= 3'd0;
    end else if (vsync_s1_s && !vsync_out) begin
      letters_en_r <= letters_en;
      sel_valid_r  <= sel_valid;
      sel_col_r    <= sel_col;
      sel_row_r    <= sel_row;
    end else begin
      letters_en_r <= letters_en_r;
      sel_valid_r  <= sel_valid_r;
      sel_col_r    <= sel_col_r;
      sel_row_r    <= sel_row_r;
    end
  end

  // band decode, glyph bit select and colour mux on the stage-1 position
  always_comb begin
    file_gx_s   = {5'd0, hcount_s1_s[5:0]} - FILE_GLYPH_OFS;
    col_idx_s   = {6'd0, hcount_s1_s[10:6]} - FILE_COL_BASE;
    row_idx_s   = {6'd0, vcount_s1_s[10:6]} - RANK_ROW_BASE;
    v_row_s     = {5'd0, vcount_s1_s[5:0]};
    rank_gx_s   = 11'd0;
    glyph_x_s   = 11'd0;
    glyph_ok_s  = 1'b0;
    glyph_bit_s = 1'b0;
    sel_hit_s   = 1'b0;
    rgb_mix_s   = rgb_s1_s;

    file_band_s = in_range(hcount_s1_s, FILE_H_MIN, FILE_H_MAX) &&
                  (in_range(vcount_s1_s, FILE_V0_MIN, FILE_V0_MAX) ||
                   in_range(vcount_s1_s, FILE_V1_MIN, FILE_V1_MAX));
    rank_band_s = in_range(vcount_s1_s, RANK_V_MIN, RANK_V_MAX) &&
                  (in_range(hcount_s1_s, RANK_H0_MIN, RANK_H0_MAX) ||
                   in_range(hcount_s1_s, RANK_H1_MIN, RANK_H1_MAX));

    if (hcount_s1_s < RANK_H1_MIN) begin
      rank_gx_s = hcount_s1_s - RANK_GLYPH_OFS0;
    end else begin
      rank_gx_s = hcount_s1_s - RANK_GLYPH_OFS1;
    end

    // an out-of-range glyph_x after unsigned wrap is treated as off, not aliased
    if (file_band_s) begin
      glyph_x_s  = file_gx_s;
      glyph_ok_s = (file_gx_s < GLYPH_W);
      sel_hit_s  = sel_valid_r && (col_idx_s == {8'd0, sel_col_r});
    end else if (rank_band_s) begin
      glyph_x_s  = rank_gx_s;
      glyph_ok_s = (rank_gx_s < GLYPH_W) && in_range(v_row_s, RANK_ROW_MIN, RANK_ROW_MAX);
      sel_hit_s  = sel_valid_r && (row_idx_s == {8'd0, sel_row_r});
    end else begin
      glyph_x_s  = 11'd0;
      glyph_ok_s = 1'b0;
      sel_hit_s  = 1'b0;
    end

    glyph_bit_s = char_pixels[3'd7 - glyph_x_s[2:0]];

    if (hblnk_s1_s || vblnk_s1_s) begin
      rgb_mix_s = rgb_s1_s;
    end else if (letters_en_r && glyph_ok_s && glyph_bit_s) begin
      if (sel_hit_s) begin
        rgb_mix_s = LETTER_HL_RGB;
      end else begin
        rgb_mix_s = LETTER_RGB;
      end
    end else begin
      rgb_mix_s = rgb_s1_s;
    end
  end

  vga_delay #(.DEPTH(1)) u_stage2 (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_s1_s), .vcount_in(vcount_s1_s),
    .hsync_in(hsync_s1_s), .vsync_in(vsync_s1_s),
    .hblnk_in(hblnk_s1_s), .vblnk_in(vblnk_s1_s), .rgb_in(rgb_mix_s),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out)
  );

endmodule

// File: tb/tb_draw_letters.sv
// Self-checking bench for draw_letters: directed label scenarios followed by random
// traffic, all compared against a per-pixel reference model of the label rules.
module tb_draw_letters;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [7:0]  char_pixels;
  logic        letters_en, sel_valid;
  logic [2:0]  sel_col, sel_row;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic [11:0] rgb;
  } vga_t;

  vga_t m_s1, m_out;
  bit   m_en, m_sv;
  int   m_sc, m_sr;

  always #5 clk = ~clk;

  draw_letters dut (
    .clk(clk), .rst(rst),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
    .char_pixels(char_pixels), .letters_en(letters_en), .sel_valid(sel_valid),
    .sel_col(sel_col), .sel_row(sel_row),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out)
  );

  // Colour a pixel from the label rules using plain integer arithmetic.
  function automatic logic [11:0] ref_rgb(vga_t s, logic [7:0] cp);
    int h, v, gx, vr;
    bit on, hl, fb, rb;
    h = int'(s.h);
    v = int'(s.v);
    on = 0;
    hl = 0;
    fb = (h >= 256 && h <= 767) && ((v >= 104 && v <= 119) || (v >= 648 && v <= 663));
    rb = (v >= 128 && v <= 639) && ((h >= 236 && h <= 243) || (h >= 780 && h <= 787));
    if (fb) begin
      gx = (h % 64) - 28;
      if (gx >= 0 && gx <= 7) on = cp[3'(7 - gx)];
      hl = m_sv && ((h / 64) - 4 == m_sc);
    end
    if (rb) begin
      gx = (h <= 243) ? h - 236 : h - 780;
      vr = v % 64;
      if (vr >= 24 && vr <= 39) on = cp[3'(7 - gx)];
      hl = m_sv && ((v / 64) - 2 == m_sr);
    end
    if (s.hb || s.vb || !m_en || !on) return s.rgb;
    return hl ? 12'hF80 : 12'hFFF;
  endfunction

  task automatic model_edge(input bit r, input vga_t x, input logic [7:0] cp,
                            input bit en, input bit sv, input int sc, input int sr);
    vga_t nxt;
    bit cap;
    if (r) begin
      m_s1 = '0; m_out = '0;
      m_en = 1; m_sv = 0; m_sc = 0; m_sr = 0;
    end else begin
      cap = m_s1.vs && !m_out.vs;
      nxt = m_s1;
      nxt.rgb = ref_rgb(m_s1, cp);
      m_out = nxt;
      m_s1 = x;
      if (cap) begin
        m_en = en; m_sv = sv; m_sc = sc; m_sr = sr;
      end
    end
  endtask

  task automatic step(input bit r, input int h, input int v, input bit hs, input bit vs,
                      input bit hb, input bit vb, input logic [11:0] rgb, input logic [7:0] cp);
    vga_t x, got;
    rst = r;
    hcount_in = h[10:0]; vcount_in = v[10:0];
    hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb;
    rgb_in = rgb; char_pixels = cp;
    x = '{h[10:0], v[10:0], hs, vs, hb, vb, rgb};
    @(posedge clk);
    model_edge(r, x, cp, letters_en, sel_valid, int'(sel_col), int'(sel_row));
    @(negedge clk);
    got = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out};
    vectors++;
    assert (got === m_out) else begin
      miscompares++;
      $error("FAIL stream in_h=%0d in_v=%0d observed=%h expected=%h", h, v, got, m_out);
    end
  endtask

  task automatic px(input int h, input int v, input logic [7:0] cp, input logic [11:0] rgb);
    step(0, h, v, 0, 0, 0, 0, rgb, cp);
  endtask

  task automatic chk_rgb(input string tag, input logic [11:0] exp);
    vectors++;
    assert (rgb_out === exp) else begin
      miscompares++;
      $error("FAIL %s observed rgb=%h expected rgb=%h", tag, rgb_out, exp);
    end
  endtask

  task automatic vsync_frame();
    step(0, 0, 0, 0, 1, 1, 1, 12'h000, 8'h00);
    step(0, 0, 0, 0, 1, 1, 1, 12'h000, 8'h00);
    step(0, 0, 0, 0, 0, 1, 1, 12'h000, 8'h00);
  endtask

  initial begin
    int h, v, sel;
    @(negedge clk);
    letters_en = 1'b1; sel_valid = 1'b0; sel_col = 3'd0; sel_row = 3'd0;
    step(1, 300, 110, 1, 1, 1, 1, 12'hABC, 8'hFF);
    step(1, 284, 104, 1, 0, 0, 0, 12'h123, 8'hFF);
    chk_rgb("reset_rgb", 12'h000);

    // plain label pixel, then a cleared glyph bit
    px(284, 104, 8'h00, 12'h123);
    px(285, 104, 8'h80, 12'h456);
    chk_rgb("file_on", 12'hFFF);
    px(284, 104, 8'h00, 12'h321);
    px(0, 0, 8'h7F, 12'h000);
    chk_rgb("file_bit_off", 12'h321);

    // glyph_x edges: 283 wraps below zero, 292 is past the glyph, 291 is the last column
    px(283, 104, 8'h00, 12'h0A1);
    px(0, 0, 8'hFF, 12'h000);
    chk_rgb("gx_wrap", 12'h0A1);
    px(292, 119, 8'h00, 12'h0A2);
    px(0, 0, 8'hFF, 12'h000);
    chk_rgb("gx_past", 12'h0A2);
    px(291, 663, 8'h00, 12'h0A3);
    px(0, 0, 8'h01, 12'h000);
    chk_rgb("gx_last", 12'hFFF);

    // column highlight on file E, plain on file D
    sel_valid = 1'b1; sel_col = 3'd4; sel_row = 3'd0;
    vsync_frame();
    px(540, 110, 8'h00, 12'h0AA);
    px(0, 0, 8'h80, 12'h000);
    chk_rgb("file_E_hl", 12'hF80);
    px(476, 110, 8'h00, 12'h0AA);
    px(0, 0, 8'h80, 12'h000);
    chk_rgb("file_D", 12'hFFF);

    // rank band glyph-row edge
    px(236, 152, 8'h00, 12'h0BB);
    px(0, 0, 8'h80, 12'h000);
    chk_rgb("rank_hl", 12'hF80);
    px(236, 151, 8'h00, 12'h0BB);
    px(0, 0, 8'h80, 12'h000);
    chk_rgb("rank_row_off", 12'h0BB);

    // blanking wins over the overlay
    step(0, 284, 104, 0, 0, 1, 0, 12'h5A5, 8'h00);
    px(0, 0, 8'hFF, 12'h000);
    chk_rgb("hblnk_pass", 12'h5A5);

    // enable dropped mid-frame only takes effect after the next vsync
    letters_en = 1'b0;
    px(284, 104, 8'h00, 12'h111);
    px(0, 0, 8'h80, 12'h000);
    chk_rgb("en_held", 12'hFFF);
    vsync_frame();
    px(284, 104, 8'h00, 12'h222);
    px(0, 0, 8'h80, 12'h000);
    chk_rgb("en_off", 12'h222);

    // mid-line reset flushes the pipe and restores default settings
    letters_en = 1'b1; sel_valid = 1'b1; sel_col = 3'd0;
    vsync_frame();
    px(284, 104, 8'h00, 12'h333);
    px(0, 0, 8'h80, 12'h000);
    chk_rgb("pre_rst_hl", 12'hF80);
    px(284, 104, 8'h00, 12'h333);
    step(1, 285, 104, 0, 0, 0, 0, 12'h777, 8'h80);
    chk_rgb("rst_out0", 12'h000);
    px(284, 104, 8'h00, 12'h444);
    chk_rgb("rst_out1", 12'h000);
    px(0, 0, 8'h80, 12'h000);
    chk_rgb("rst_latch", 12'hFFF);

    // random traffic biased toward the label bands
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        letters_en = 1'($urandom);
        sel_valid  = 1'($urandom);
        sel_col    = 3'($urandom);
        sel_row    = 3'($urandom);
      end
      sel = int'($urandom_range(0, 99));
      if (sel < 3) begin
        vsync_frame();
      end else if (sel < 4) begin
        step(1, int'($urandom_range(0, 1023)), int'($urandom_range(0, 767)), 0, 0, 0, 0,
             12'($urandom), 8'($urandom));
      end else begin
        case ($urandom_range(0, 3))
          0: begin
            h = int'($urandom_range(0, 1023));
            v = int'($urandom_range(0, 767));
          end
          1: begin
            h = 256 + 64 * int'($urandom_range(0, 7)) + int'($urandom_range(24, 37));
            v = ($urandom_range(0, 1) == 0) ? int'($urandom_range(100, 123))
                                            : int'($urandom_range(644, 667));
          end
          default: begin
            h = ($urandom_range(0, 1) == 0) ? int'($urandom_range(232, 247))
                                            : int'($urandom_range(776, 791));
            v = int'($urandom_range(124, 643));
          end
        endcase
        step(0, h, v, 1'($urandom), 1'b0, ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 9) == 0), 12'($urandom), 8'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/draw_letters.md
DRAW_LETTERS -- requirements
Module: draw_letters

Interface
REQ-001 clk  input  1  system pixel clock; all state updates on its rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 hcount_in, vcount_in  input  11 each  current pixel position from the upstream VGA stage.
REQ-004 hsync_in, vsync_in, hblnk_in, vblnk_in  input  1 each  upstream timing signals, aligned with hcount_in/vcount_in.
REQ-005 rgb_in  input  12  upstream pixel colour {R[3:0],G[3:0],B[3:0]}.
REQ-006 char_pixels  input  8  font ROM row for the position presented one cycle earlier; bit 7 is the leftmost glyph pixel.
REQ-007 letters_en  input  1  draws board labels when 1.
REQ-008 sel_valid  input  1  a board square is selected.
REQ-009 sel_col, sel_row  input  3 each  selected square: column 0=A..7=H; row 0=top rank "8"..7=bottom rank "1".
REQ-010 hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out  output  same widths  delayed VGA stream with labels overlaid.

Function
REQ-011 The block SHALL delay every VGA input by exactly 2 clk cycles to its output: stage 1 aligns with char_pixels, stage 2 is the registered output.
REQ-012 All overlay decisions SHALL use the stage-1 copies of hcount/vcount with the char_pixels value present in that same cycle.
REQ-013 File band: 256<=h<=767 and (104<=v<=119 or 648<=v<=663); glyph_x = h[5:0]-28, valid only for 0..7; col_idx = h[10:6]-4.
REQ-014 Rank band: 128<=v<=639 and (236<=h<=243 or 780<=h<=787); glyph_x = h-236 or h-780; glyph row valid only when v[5:0] is 24..39; row_idx = v[10:6]-2.
REQ-015 Pixel on: latched enable is 1, position lies in a band with valid glyph_x and glyph row, and char_pixels[7-glyph_x] is 1.
REQ-016 Pixel on: rgb_out SHALL be LETTER_HL_RGB if latched sel_valid is 1 and (file band and col_idx==sel_col, or rank band and row_idx==sel_row); otherwise LETTER_RGB.
REQ-017 Pixel off, or hblnk/vblnk set at stage 1: rgb_out SHALL equal delayed rgb_in unmodified; blanking SHALL override the overlay.
REQ-018 Frame latch: on the cycle where stage-1 vsync goes 0->1, the block SHALL capture letters_en, sel_valid, sel_col and sel_row; the values SHALL then hold for the whole next frame.
REQ-019 Input changes between vsync rising edges SHALL NOT affect the pixels currently being drawn.
REQ-020 Arithmetic SHALL use 11-bit unsigned values; wrap of glyph_x outside 0..7 SHALL count as off, never as an alias.

Reset
REQ-021 While rst=1, all outputs and both pipeline stages SHALL be 0 (rgb_out=12'h000, syncs and blanks 0).
REQ-022 While rst=1, the latched letters_en SHALL be 1 and the latched sel_valid SHALL be 0, with sel_col/sel_row at 0.
REQ-023 After rst falls, the first valid output SHALL appear 2 cycles after the first post-reset input.
REQ-024 A reset in mid-frame SHALL flush the pipeline; no pre-reset pixel SHALL reach the output.

Structure
REQ-025 LETTER_RGB (12'hFFF), LETTER_HL_RGB (12'hF80), band bounds and the 28/236/780 glyph offsets SHALL be constants in vga_pkg.
REQ-026 One sub-module, vga_delay (parameterised depth, carries the full VGA bundle), SHALL be used for the stage registers; band/bit decode SHALL stay in draw_letters.

Verification
REQ-027 Scenario: h=284, v=104 with char_pixels=8'h80 at the next cycle -> rgb_out=12'hFFF 2 cycles after the input; char_pixels=8'h7F -> rgb_in passes through.
REQ-028 Scenario: sel_valid=1, sel_col=4 latched at vsync; the "E" glyph at h=540, v=110 with its bit set -> 12'hF80; the "D" glyph at h=476 -> 12'hFFF.
REQ-029 Scenario: rank band h=236, v[5:0]=24, sel_row=0 latched, char_pixels=8'h80 -> 12'hF80; v[5:0]=23 -> passthrough.
REQ-030 Scenario: letters_en changed to 0 mid-frame -> labels stay drawn until the next vsync rising edge, then rgb_out==delayed rgb_in everywhere.
REQ-031 Scenario: hblnk_in=1 inside a band with char_pixels=8'hFF -> rgb_out equals delayed rgb_in.
REQ-032 Scenario: rst asserted for 1 cycle mid-line -> next 2 outputs 0; the latch returns to its reset values (labels on, no highlight).
